truth_table_sweeper: RTL
========================

# truth_table_sweeper

Sequential stimulus-and-capture stage wrapped around the six-input combinational logic block. Walks all 64 input combinations on outputs A..F, waits a fixed settle time per vector, samples the block's Y output, and builds the full 64-entry truth table plus a count of ones. Replaces hand-written `#delay` stimulus with a synthesizable, self-timed sweep whose result a bench or host reads after `done`.

## Interface
- `SETTLE`, default 2: cycles each vector is held before Y is sampled. Legal range is 1..15; 0 is illegal (elaboration check).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level-sampled sweep request. Acted on only in IDLE or DONE.
- `A`,`B`,`C`,`D`,`E`,`F` out 1 each: stimulus to the logic block. `A` = index[5] (MSB), `F` = index[0].
- `y_in` in 1: Y from the logic block.
- `busy` out 1: high in SETTLE and SAMPLE.
- `done` out 1: high in DONE.
- `table_out` out 64: bit *i* = Y sampled while index = *i*.
- `ones_count` out 7: number of set bits in `table_out` (0..64).

## Operation
- **States** (`IDLE`, `SETTLE`, `SAMPLE`, `DONE`):
  - IDLE + `start` → SETTLE. Sets index=0 and settle_cnt=0, and clears `table_out` and `ones_count`.
  - SETTLE: if settle_cnt == SETTLE-1 → SAMPLE; otherwise settle_cnt+1.
  - SAMPLE: writes `table_out[index]` ← `y_in` and adds `y_in` to `ones_count`. If index == 63 → DONE. Otherwise index+1, settle_cnt=0, → SETTLE.
  - DONE: holds results. `start` → SETTLE with the same clearing as IDLE. No `start` → stay in DONE.
- **Outputs:** A..F are driven from the registered index in every state. They read 0 in IDLE and 63 in DONE.
- **Widths:**
  - index: 6 bits. No wrap; the sweep terminates at 63.
  - `ones_count`: 7 bits, so it cannot overflow.
  - settle_cnt: 4 bits.
- **Boundary conditions:**
  - `start` while `busy`: ignored. The sweep is not restarted.
  - `start` held high continuously: a new sweep begins on the cycle after DONE is entered. `done` pulses for 1 cycle.
  - Reset mid-sweep: immediate return to IDLE. All outputs return to reset values and the partial table is discarded.
  - `y_in` is sampled only in SAMPLE; its value in any other state has no effect.

## Timing
- **Reset values:** state=IDLE, A..F=0, `busy`=0, `done`=0, `table_out`=0, `ones_count`=0.
- **Vector hold:** each vector is held for SETTLE+1 cycles (SETTLE cycles in SETTLE plus 1 in SAMPLE). Y for vector *i* is captured at the edge ending its SAMPLE cycle.
- **Sweep latency:** let edge 0 be the edge that samples `start`. `done` rises after edge 64×(SETTLE+1); the default is edge 192.
- **Output staging:** all outputs are registered. `table_out` bit *i* becomes visible the cycle after vector *i*'s SAMPLE.
- **Combinational path:** the logic block's path is A..F → Y → `y_in`. It must meet SETTLE cycles; SETTLE ≥ 1 guarantees at least one full cycle.

## Structure
- **Shared package `sweeper_pkg`:**
  - state enum (`IDLE`, `SETTLE`, `SAMPLE`, `DONE`)
  - `N_IN`=6, `N_VEC`=64, `CNT_W`=7
- **Sub-module `settle_timer`:** loadable down-counter with a terminal flag, reusable for other self-timed stimulus stages. The index, table and FSM stay in the top module.
- **Top-level wiring:** the logic block is not instantiated inside `truth_table_sweeper`; the top level wires them together.

## Test plan
- Y = A&B, SETTLE=2, `start` pulse → `done` at edge 192, `table_out`=64'hFFFF_0000_0000_0000, `ones_count`=16.
- Y tied 0, then Y tied 1 → `table_out`=0 with `ones_count`=0; then `table_out`=all ones with `ones_count`=64.
- Y = A^B^C^D^E^F, SETTLE=1 → `table_out`=64'h6996_9669_9669_6996, `ones_count`=32, `done` at edge 128.
- `start` pulse again at index 20 → ignored: A..F continue 21, 22, …; `done` timing unchanged.
- `rst` asserted at index 40, released 3 cycles later → A..F=0, `table_out`=0, `busy`=0, `done`=0 immediately; a later `start` gives a correct full sweep.
- `start` held high through DONE → `done` high exactly 1 cycle, then `busy`=1 and A..F=0. The second sweep's result matches the first.

Source files
------------

// File: rtl/sweeper_pkg.sv
// Shared definitions for the truth-table sweep stage: vector geometry,
// counter widths and the sweep FSM state type.
package sweeper_pkg;

  // Number of stimulus bits driven to the logic block (A..F).
  localparam int N_IN  = 6;
  // Number of input combinations walked by one sweep.
  localparam int N_VEC = 64;
  // Width of the ones counter; holds 0..N_VEC without overflow.
  localparam int CNT_W = 7;
  // Width of the settle timer; covers settle times 1..15.
  localparam int TMR_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // A sweep is in flight while a vector is being held or sampled.
  function automatic logic is_busy(input state_t s);
    return (s == S_SETTLE) || (s == S_SAMPLE);
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter with a terminal flag. Load the number of extra
// cycles to wait, then decrement until the count reaches zero. Usable by
// any self-timed stimulus stage that must hold a vector for a fixed time.
module settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_term
);

  logic [W-1:0] r_count;

  // Count register: load has priority, decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_term = (r_count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Self-timed stimulus-and-capture stage. Walks all 64 combinations on
// A..F, holds each for SETTLE cycles before sampling y_in, and records the
// resulting truth table plus its population count. The logic block under
// test is wired to A..F / y_in outside this module.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic             D,
  output logic             E,
  output logic             F,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic [N_VEC-1:0] table_out,
  output logic [CNT_W-1:0] ones_count
);

  // A zero settle time would sample Y in the same cycle the vector
  // changes, leaving the logic block no time to propagate.
  if ((SETTLE < 1) || (SETTLE > 15)) begin : g_bad_settle
    $error("truth_table_sweeper: SETTLE must be in 1..15");
  end

  // The timer counts down from SETTLE-1 so its terminal flag marks the
  // last settle cycle of each vector.
  localparam logic [TMR_W-1:0] LP_TMR_LOAD = TMR_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  LP_LAST_IDX = N_IN'(N_VEC - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [N_IN-1:0]   r_index;
  logic [N_VEC-1:0]  r_table;
  logic [CNT_W-1:0]  r_ones;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_last;
  logic              w_sample;
  logic              w_tmr_load;
  logic              w_tmr_dec;
  logic              w_tmr_term;

  // A new sweep is accepted only when no sweep is in flight.
  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last     = (r_index == LP_LAST_IDX);
  assign w_sample   = (r_state == S_SAMPLE);

  // Reload the timer whenever a vector starts its settle window.
  assign w_tmr_load = w_accept || (w_sample && !w_last);
  assign w_tmr_dec  = (r_state == S_SETTLE);

  settle_timer #(
    .W (TMR_W)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (LP_TMR_LOAD),
    .i_dec      (w_tmr_dec),
    .o_term     (w_tmr_term)
  );

  // Next-state decode for the sweep FSM.
  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch
    // is inferred.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (w_tmr_term) w_state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        w_state_nxt = w_last ? S_DONE : S_SETTLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State plus registered busy/done flags decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= is_busy(w_state_nxt);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Vector index, captured table and ones count.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the 64-entry table is a plain flop vector, not a RAM, so it is
    // reset along with the rest; a reset must discard any partial table.
    if (rst) begin
      r_index <= '0;
      r_table <= '0;
      r_ones  <= '0;
    end else if (w_accept) begin
      r_index <= '0;
      r_table <= '0;
      r_ones  <= '0;
    end else if (w_sample) begin
      r_table[r_index] <= y_in;
      r_ones           <= r_ones + {{(CNT_W-1){1'b0}}, y_in};
      if (!w_last) r_index <= r_index + 1'b1;
    end
  end

  // A is the index MSB, F the LSB.
  assign {A, B, C, D, E, F} = r_index;
  assign busy               = r_busy;
  assign done               = r_done;
  assign table_out          = r_table;
  assign ones_count         = r_ones;

endmodule
